// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM state encoding,
// requester IDs and the default watchdog limit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  localparam int WATCHDOG_CYCLES_DEFAULT = 40;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == REQ_ID_1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/multdiv_arbiter_if.sv
// Bundle of the two requester handshakes plus the shared Booth multiplier port.
// slave: the arbiter; master: requesters and multiplier around it.
interface multdiv_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_p;
  logic        resp_exc;

  logic        mult_start;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] mult_p;
  logic        mult_rdy;
  logic        mult_exc;

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, resp_ready,
           mult_p, mult_rdy, mult_exc,
    output req_ready, resp_valid, resp_p, resp_exc,
           mult_start, mult_a, mult_b
  );

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, resp_ready,
           mult_p, mult_rdy, mult_exc,
    input  req_ready, resp_valid, resp_p, resp_exc,
           mult_start, mult_a, mult_b
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection; the pointer moves to the requester
// not just served whenever a response handshake completes.
module rr_arbiter2
  import multdiv_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       served,
  input  logic       served_id,
  output logic       grant_valid,
  output logic       grant_id
);

  logic ptr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_valid = |req_valid;
    grant_id    = REQ_ID_0;
    unique case (req_valid)
      2'b10:   grant_id = REQ_ID_1;
      2'b11:   grant_id = ptr;
      default: grant_id = REQ_ID_0;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= REQ_ID_0;
    end else if (served) begin
      ptr <= ~served_id;
    end
  end

endmodule

// File: rtl/multdiv_arbiter.sv
// Arbitrates two requesters onto one shared Booth multiplier (IDLE/START/BUSY/DONE).
// Optional BUSY watchdog enabled by defining MULTARB_WATCHDOG_EN.
module multdiv_arbiter
  import multdiv_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  multdiv_arbiter_if.slave   bus
);

  state_t      state;
  logic        cur_id;
  logic        grant_valid;
  logic        grant_id;
  logic [1:0]  req_ready_c;
  logic        accept;
  logic        resp_hs;

  logic [1:0]  resp_valid_q;
  logic [31:0] resp_p_q;
  logic        resp_exc_q;
  logic        mult_start_q;
  logic [31:0] mult_a_q;
  logic [31:0] mult_b_q;

`ifdef MULTARB_WATCHDOG_EN
  localparam int unsigned WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  rr_arbiter2 u_rr (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (bus.req_valid),
    .served     (resp_hs),
    .served_id  (cur_id),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Acceptance is combinational so a waiting requester is taken on the first IDLE edge.
  always_comb begin
    req_ready_c = 2'b00;
    if (reset_n && state == IDLE && grant_valid) begin
      req_ready_c = id_onehot(grant_id);
    end
  end

  assign accept  = |req_ready_c;
  assign resp_hs = (state == DONE) && bus.resp_ready[cur_id];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cur_id       <= REQ_ID_0;
      resp_valid_q <= 2'b00;
      resp_p_q     <= '0;
      resp_exc_q   <= 1'b0;
      mult_start_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
`ifdef MULTARB_WATCHDOG_EN
      wd_cnt       <= '0;
`endif
    end else begin
      mult_start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cur_id       <= grant_id;
            mult_a_q     <= (grant_id == REQ_ID_1) ? bus.req1_a : bus.req0_a;
            mult_b_q     <= (grant_id == REQ_ID_1) ? bus.req1_b : bus.req0_b;
            mult_start_q <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          state <= BUSY;
`ifdef MULTARB_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        BUSY: begin
          if (bus.mult_rdy) begin
            resp_p_q     <= bus.mult_p;
            resp_exc_q   <= bus.mult_exc;
            resp_valid_q <= id_onehot(cur_id);
            state        <= DONE;
`ifdef MULTARB_WATCHDOG_EN
          end else if (wd_cnt == WD_LAST) begin
            // Multiplier hung: report an aborted operation instead of waiting forever.
            resp_p_q     <= '0;
            resp_exc_q   <= 1'b1;
            resp_valid_q <= id_onehot(cur_id);
            state        <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          if (resp_hs) begin
            resp_valid_q <= 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_p     = resp_p_q;
  assign bus.resp_exc   = resp_exc_q;
  assign bus.mult_start = mult_start_q;
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;

endmodule
